// File: rtl/rv_mem_resp.sv
// Memory-side responder: latches one word request, waits WAIT_CYCLES, then accesses an
// internal word RAM and returns rdata/err with a single-cycle ready pulse.
module rv_mem_resp #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        memrw,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES);

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          memrw_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic [31:0]   rdata_q;
    logic          ready_q;
    logic          err_q;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          capture;
    logic          do_resp;
    logic          acc_err;
    logic [AW-1:0] idx;
    logic [31:0]   merged;

    assign idx     = addr_q[AW+1:2];
    // Anything above the RAM's byte range, or a misaligned address, is rejected.
    assign acc_err = (addr_q[1:0] != 2'b00) || (addr_q[31:AW+2] != '0);
    assign do_resp = (state_q == StResp);

    always_comb begin
        merged = mem[idx];
        for (int i = 0; i < 4; i++) begin
            if (be_q[i]) begin
                merged[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            StIdle: begin
                if (req) begin
                    capture = 1'b1;
                    cnt_d   = WaitLoad;
                    state_d = (WaitLoad != 4'd0) ? StWait : StResp;
                end
            end
            StWait: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end
                if (cnt_q <= 4'd1) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            memrw_q <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            ready_q <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= do_resp;
            if (capture) begin
                memrw_q <= memrw;
                addr_q  <= addr;
                wdata_q <= wdata;
                be_q    <= be;
            end
            if (do_resp) begin
                err_q   <= acc_err;
                rdata_q <= acc_err ? 32'd0 : (memrw_q ? merged : mem[idx]);
            end
        end
    end

    // RAM is not reset; an async reset drops state_q out of StResp, so an aborted write is lost.
    always_ff @(posedge clk) begin
        if (do_resp && memrw_q && !acc_err) begin
            mem[idx] <= merged;
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign err   = err_q;

endmodule

// File: tb/tb_rv_mem_resp.sv
// Scoreboard bench for rv_mem_resp: two instances (0 and 3 wait states) checked against a
// word-array reference model.
module tb_rv_mem_resp;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned W0    = 0;
    localparam int unsigned W1    = 3;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_v   [2];
    logic        memrw_v [2];
    logic [31:0] addr_v  [2];
    logic [31:0] wdata_v [2];
    logic [3:0]  be_v    [2];
    logic [31:0] rdata0, rdata1;
    logic        ready0, ready1;
    logic        err0, err1;

    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    logic [31:0] mdl [2][16];

    always #5 clk = ~clk;

    rv_mem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req(req_v[0]), .memrw(memrw_v[0]), .addr(addr_v[0]),
        .wdata(wdata_v[0]), .be(be_v[0]), .rdata(rdata0), .ready(ready0), .err(err0)
    );

    rv_mem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req_v[1]), .memrw(memrw_v[1]), .addr(addr_v[1]),
        .wdata(wdata_v[1]), .be(be_v[1]), .rdata(rdata1), .ready(ready1), .err(err1)
    );

    function automatic logic get_ready(input int sel);
        return (sel == 0) ? ready0 : ready1;
    endfunction

    function automatic logic [31:0] get_rdata(input int sel);
        return (sel == 0) ? rdata0 : rdata1;
    endfunction

    function automatic logic get_err(input int sel);
        return (sel == 0) ? err0 : err1;
    endfunction

    task automatic check(input string name, input int sel, input logic [31:0] act,
                         input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s dut%0d: got 0x%08h expected 0x%08h", name, sel, act, exp);
    endtask

    // Monitors: every ready pulse pops one expected response.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ready0 === 1'b1) begin
            if (q0.size() == 0) begin
                check("spurious_ready", 0, {31'b0, ready0}, 32'd0);
            end else begin
                e0 = q0.pop_front();
                check("rdata", 0, rdata0, e0.rdata);
                check("err", 0, {31'b0, err0}, {31'b0, e0.err});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && ready1 === 1'b1) begin
            if (q1.size() == 0) begin
                check("spurious_ready", 1, {31'b0, ready1}, 32'd0);
            end else begin
                e1 = q1.pop_front();
                check("rdata", 1, rdata1, e1.rdata);
                check("err", 1, {31'b0, err1}, {31'b0, e1.err});
            end
        end
    end

    // Issue one access at a negedge; model result goes to the scoreboard, then wait for ready.
    task automatic access(input int sel, input logic rw, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] b);
        exp_t e;
        int   wi;
        int   k;
        int   lat;
        if (a[1:0] != 2'b00 || a >= 4 * DEPTH) begin
            e.rdata = 32'd0;
            e.err   = 1'b1;
        end else begin
            wi = int'(a[5:2]);
            if (rw) begin
                for (int i = 0; i < 4; i++) begin
                    if (b[i]) mdl[sel][wi][8*i +: 8] = wd[8*i +: 8];
                end
            end
            e.rdata = mdl[sel][wi];
            e.err   = 1'b0;
        end
        if (sel == 0) q0.push_back(e);
        else q1.push_back(e);

        req_v[sel]   = 1'b1;
        memrw_v[sel] = rw;
        addr_v[sel]  = a;
        wdata_v[sel] = wd;
        be_v[sel]    = b;
        lat = (sel == 0) ? int'(W0) + 2 : int'(W1) + 2;
        k = 0;
        while (k < 40) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                // Garbage write-looking inputs while busy must be ignored.
                req_v[sel]   = 1'b0;
                memrw_v[sel] = 1'b1;
                addr_v[sel]  = ($urandom_range(0, 1) == 1) ? 32'h20 : $urandom;
                wdata_v[sel] = $urandom;
                be_v[sel]    = 4'hF;
            end
            if (get_ready(sel) === 1'b1) break;
        end
        check("latency", sel, k, lat);
        @(negedge clk);
        check("ready_pulse_width", sel, {31'b0, get_ready(sel)}, 32'd0);
    endtask

    task automatic abort_write(input int sel);
        req_v[sel]   = 1'b1;
        memrw_v[sel] = 1'b1;
        addr_v[sel]  = 32'h30;
        wdata_v[sel] = 32'h5555_5555;
        be_v[sel]    = 4'hF;
        @(negedge clk);
        req_v[sel] = 1'b0;
        rst_n      = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_rdata", sel, get_rdata(sel), 32'd0);
        check("reset_err", sel, {31'b0, get_err(sel)}, 32'd0);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("abort_no_ready", sel, {31'b0, get_ready(sel)}, 32'd0);
        end
    endtask

    task automatic run_suite(input int sel);
        logic [31:0] a;
        int          kind;
        for (int w = 0; w < 16; w++) access(sel, 1'b1, 32'(w) << 2, $urandom, 4'hF);
        access(sel, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        access(sel, 1'b0, 32'h10, 32'h0, 4'h0);
        access(sel, 1'b1, 32'h20, 32'h1122_3344, 4'hF);
        access(sel, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101);
        access(sel, 1'b0, 32'h20, 32'h0, 4'h0);
        access(sel, 1'b1, 32'h24, 32'hFFFF_FFFF, 4'b0000);
        access(sel, 1'b0, 32'h24, 32'h0, 4'h0);
        access(sel, 1'b0, 32'h13, 32'h0, 4'h0);
        access(sel, 1'b1, 32'h1000, 32'hCAFE_F00D, 4'hF);
        access(sel, 1'b0, 32'h0, 32'h0, 4'h0);
        access(sel, 1'b0, 32'h10, 32'h0, 4'h0);
        access(sel, 1'b0, 32'h20, 32'h0, 4'h0);
        abort_write(sel);
        access(sel, 1'b0, 32'h30, 32'h0, 4'h0);
        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 7));
            if (kind < 6) a = 32'($urandom_range(0, 15)) << 2;
            else if (kind == 6) a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
            else if ($urandom_range(0, 1) == 1) a = 32'h1000 + (32'($urandom_range(0, 4095)) << 2);
            else a = $urandom | 32'h8000_0000;
            access(sel, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
        end
        for (int w = 0; w < 16; w++) access(sel, 1'b0, 32'(w) << 2, 32'h0, 4'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            req_v[s]   = 1'b0;
            memrw_v[s] = 1'b0;
            addr_v[s]  = 32'd0;
            wdata_v[s] = 32'd0;
            be_v[s]    = 4'd0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                check("idle_ready", s, {31'b0, get_ready(s)}, 32'd0);
                check("idle_rdata", s, get_rdata(s), 32'd0);
                check("idle_err", s, {31'b0, get_err(s)}, 32'd0);
            end
        end
        run_suite(0);
        run_suite(1);
        repeat (4) @(negedge clk);
        check("queue_drained", 0, q0.size(), 32'd0);
        check("queue_drained", 1, q1.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/rv_mem_resp.md
Name: rv_mem_resp

Overview:
Memory-side responder for the multicycle RISC-V core's data/instruction memory port. It accepts a single-word read or write request from the control/datapath side, holds it for a configurable number of wait states, then performs the access on an internal word-addressed RAM. It returns the result with a one-cycle ready pulse. The core's wait-state handling is built against this block.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the internal RAM; power of two, at least 4.
WAIT_CYCLES, 2, wait states inserted between request capture and response; range 0..15.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous reset, active-low.
req  input  1  request strobe; sampled only in IDLE.
memrw  input  1  access type: 1 = write, 0 = read (same encoding the control FSM drives).
addr  input  32  byte address; must be word-aligned.
wdata  input  32  write data.
be  input  4  byte enables for writes; be[i] enables wdata[8i+7:8i]. Ignored for reads.
rdata  output  32  read data; valid from the ready cycle until the next ready.
ready  output  1  single-cycle completion pulse.
err  output  1  error flag; valid with ready and held until the next ready.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, ready=0, rdata=0, err=0, wait counter=0, latched request registers=0.
  - RAM contents are not cleared.
- States:
  - IDLE: ready=0. If req=1 at an edge, latch addr/wdata/be/memrw and load cnt=WAIT_CYCLES. Go to WAIT if WAIT_CYCLES>0, else go to RESP.
  - WAIT: cnt decrements by 1 each cycle. When cnt==1 at an edge, go to RESP.
  - RESP: perform the access using the latched values. Next state is always IDLE.
- Outputs: ready, rdata and err are registered, so ready=1 for exactly the cycle after the RESP edge.
- Latency: req sampled at edge N gives ready=1 in the cycle after edge N+WAIT_CYCLES+1.
  - WAIT_CYCLES=0: ready is seen two cycles after req is seen.
- Inputs (addr, wdata, be, memrw, req) are ignored outside IDLE; changes during WAIT/RESP have no effect.
- Back-to-back access: if req is still 1 when the block returns to IDLE, it is a new request. The requester must drop req after ready to avoid a duplicate access.
- Address decode: word index = addr[log2(DEPTH_WORDS)+1:2].
- Error conditions: addr[1:0]!=0, or addr >= 4*DEPTH_WORDS. On error:
  - err=1, no RAM write, rdata=0, ready still pulses.
- Read: rdata = RAM[index], with err=0.
- Write:
  - For each i with be[i]=1, byte i of RAM[index] is updated.
  - be=4'b0000 is a legal no-op write.
  - rdata is set to the post-write word, and err=0.
- Read-after-write to the same address in consecutive accesses returns the new data (no forwarding hazard, since accesses are serialized).
- Reset during WAIT or RESP (before the RESP edge completes): access aborted, no RAM write, ready=0.
- Counter is 4 bits and never wraps below 0: WAIT is left at cnt==1.
- No simultaneous requests are possible (single port). An illegal state encoding recovers to IDLE.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles, release, req=0 for 10 cycles -> ready=0, rdata=0, err=0 throughout.
- Write then read: write addr=0x10, wdata=0xDEADBEEF, be=4'hF; then read addr=0x10 -> each ready arrives exactly WAIT_CYCLES+2 cycles after req asserted (4 with default), read rdata=0xDEADBEEF, err=0.
- Partial write: pre-write 0x11223344 to 0x20; write 0xAABBCCDD with be=4'b0101; read 0x20 -> rdata=0x11BB33DD.
- Errors:
  - Read addr=0x13 -> err=1, rdata=0.
  - Write addr=4*DEPTH_WORDS (0x1000) -> err=1, and a later read of 0x0 is unchanged.
- Input changes during WAIT: issue a read of 0x10; during WAIT change addr to 0x20 and memrw to 1 -> response returns the 0x10 data, and 0x20 is not modified.
- Reset mid-access: start a write 0x55555555 to 0x30, pull rst_n low during WAIT, release, read 0x30 -> old contents returned, and no ready pulse from the aborted access.
- Run these with WAIT_CYCLES=0 and WAIT_CYCLES=3.
